// File: rtl/count_ctrl.sv
// -----------------------------------------------------------------------------
// count_ctrl
//   Start/stop/clear controller placed in front of the 00-99 counter display.
//   It debounces the two raw push-buttons, turns carry (count reached 99) into
//   a single event, and runs an IDLE/RUN/PAUSE/DONE state machine. The state
//   machine drives the counter enable level and a one-cycle clear pulse.
//   Everything is clocked by the board clock.
//
// Parameters
//   DEB_CNT    consecutive stable cycles needed before a key change is accepted
//   AUTO_STOP  1: a carry rising edge while in RUN moves to DONE; 0: ignored
//
// Ports
//   clk       in   board clock
//   reset     in   asynchronous, active-high reset of all state
//   key_ss    in   raw start/stop button (high = pressed), asynchronous
//   key_clr   in   raw clear button (high = pressed), asynchronous
//   carry_in  in   counter carry level from the slow counter clock domain
//   enable    out  counter enable, high only in RUN
//   clear     out  one-cycle pulse that zeroes the counter
//   state     out  IDLE=00, RUN=01, PAUSE=10, DONE=11
//   run_led   out  copy of enable for the front-panel LED
// -----------------------------------------------------------------------------
module count_ctrl #(
    parameter int DEB_CNT   = 1_000_000,
    parameter bit AUTO_STOP = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_ss,
    input  logic       key_clr,
    input  logic       carry_in,
    output logic       enable,
    output logic       clear,
    output logic [1:0] state,
    output logic       run_led
);

    localparam int CW = $clog2(DEB_CNT + 1);
    // The counter value that, once incremented, would reach DEB_CNT.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    // Index 0 = start/stop, index 1 = clear.
    logic [1:0] w_key_raw;
    logic [1:0] w_press;

    assign w_key_raw = {key_clr, key_ss};

    // -------------------------------------------------------------------------
    // Per-key synchronizer, debounce counter and press detector
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_key
            logic [1:0]    r_sync;
            logic [CW-1:0] r_cnt;
            logic          r_stb;
            logic          r_stb_d;
            logic          r_press;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_sync  <= 2'b00;
                    r_cnt   <= '0;
                    r_stb   <= 1'b0;
                    r_stb_d <= 1'b0;
                    r_press <= 1'b0;
                end else begin
                    r_sync <= {r_sync[0], w_key_raw[gi]};
                    // Any sample agreeing with the accepted level restarts the
                    // count, so a bounce always starts the wait over from zero.
                    if (r_sync[1] == r_stb) begin
                        r_cnt <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_stb <= ~r_stb;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                    r_stb_d <= r_stb;
                    // Only presses (0->1 of the debounced level) are events.
                    r_press <= r_stb & ~r_stb_d;
                end
            end

            assign w_press[gi] = r_press;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Carry synchronizer and rising-edge detector: a held carry gives one event
    // -------------------------------------------------------------------------
    logic [1:0] r_carry_sync;
    logic       r_carry_d;
    logic       r_carry_evt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_carry_sync <= 2'b00;
            r_carry_d    <= 1'b0;
            r_carry_evt  <= 1'b0;
        end else begin
            r_carry_sync <= {r_carry_sync[0], carry_in};
            r_carry_d    <= r_carry_sync[1];
            r_carry_evt  <= r_carry_sync[1] & ~r_carry_d;
        end
    end

    // -------------------------------------------------------------------------
    // State machine. Priority: clear key > start/stop key > carry event.
    // -------------------------------------------------------------------------
    function automatic state_t f_next(input state_t cur, input logic ss,
                                      input logic clr, input logic cev);
        state_t nxt;
        nxt = cur;
        if (clr) begin
            nxt = ST_IDLE;
        end else if (ss) begin
            case (cur)
                ST_IDLE:  nxt = ST_RUN;
                ST_RUN:   nxt = ST_PAUSE;
                ST_PAUSE: nxt = ST_RUN;
                default:  nxt = ST_IDLE;
            endcase
        end else if (cev && AUTO_STOP && (cur == ST_RUN)) begin
            nxt = ST_DONE;
        end
        return nxt;
    endfunction

    logic   w_ss_evt;
    logic   w_clr_evt;
    state_t w_state_next;
    logic   w_clear_next;
    state_t r_state;
    logic   r_enable;
    logic   r_run_led;
    logic   r_clear;

    assign w_ss_evt     = w_press[0];
    assign w_clr_evt    = w_press[1];
    assign w_state_next = f_next(r_state, w_ss_evt, w_clr_evt, r_carry_evt);
    // Clear accompanies every entry into IDLE, including IDLE -> IDLE on clr.
    assign w_clear_next = w_clr_evt | (w_ss_evt & (r_state == ST_DONE));

    // Outputs are registered from the next state so enable drops in the very
    // cycle the state leaves RUN and clear lines up with the new IDLE state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_enable  <= 1'b0;
            r_run_led <= 1'b0;
            r_clear   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_enable  <= (w_state_next == ST_RUN);
            r_run_led <= (w_state_next == ST_RUN);
            r_clear   <= w_clear_next;
        end
    end

    assign state   = r_state;
    assign enable  = r_enable;
    assign run_led = r_run_led;
    assign clear   = r_clear;

endmodule

// File: tb/tb_count_ctrl.sv
// -----------------------------------------------------------------------------
// tb_count_ctrl
//   Two instances (AUTO_STOP=1 and AUTO_STOP=0, DEB_CNT=4) share the same
//   stimulus. A few directed reset/latency scenarios run first, then random
//   key/carry activity is fed to a reference model that pushes every predicted
//   output change into a per-instance queue; a monitor pops and compares
//   whenever an instance's state/clear outputs change.
// -----------------------------------------------------------------------------
module tb_count_ctrl;

    localparam int DEB  = 4;
    localparam int NMAX = 3000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic key_ss = 1'b0;
    logic key_clr = 1'b0;
    logic carry_in = 1'b0;

    logic [1:0][1:0] st;
    logic [1:0]      en;
    logic [1:0]      clr_o;
    logic [1:0]      led;

    count_ctrl #(.DEB_CNT(DEB), .AUTO_STOP(1'b1)) u_dut (
        .clk(clk), .reset(reset), .key_ss(key_ss), .key_clr(key_clr),
        .carry_in(carry_in), .enable(en[0]), .clear(clr_o[0]),
        .state(st[0]), .run_led(led[0])
    );

    count_ctrl #(.DEB_CNT(DEB), .AUTO_STOP(1'b0)) u_dut_ns (
        .clk(clk), .reset(reset), .key_ss(key_ss), .key_clr(key_clr),
        .carry_in(carry_in), .enable(en[1]), .clear(clr_o[1]),
        .state(st[1]), .run_led(led[1])
    );

    always #5 clk = ~clk;

    // Number of rising edges since reset was released.
    int cyc;
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        int         edge_no;
        logic [1:0] st;
        logic       clr;
    } txn_t;

    txn_t q0[$];
    txn_t q1[$];

    bit raw_ss[NMAX];
    bit raw_clr[NMAX];
    bit raw_cy[NMAX];
    bit ss_at[NMAX];
    bit clr_at[NMAX];
    bit cy_at[NMAX];
    bit stb_m[2];
    logic [1:0] m_st[2];
    logic       m_clr[2];

    function automatic bit raw_of(int k, int idx);
        if (idx < 0) return 1'b0;   // everything reads as released before reset release
        return (k == 0) ? raw_ss[idx] : raw_clr[idx];
    endfunction

    // Transition table: returns {clear, next_state}.
    function automatic logic [2:0] ref_next(logic [1:0] s, bit ss, bit cl, bit cy, bit auto_stop);
        if (cl) return {1'b1, 2'd0};
        if (ss) begin
            case (s)
                2'd0:    return {1'b0, 2'd1};
                2'd1:    return {1'b0, 2'd2};
                2'd2:    return {1'b0, 2'd1};
                default: return {1'b1, 2'd0};
            endcase
        end
        if (cy && auto_stop && s == 2'd1) return {1'b0, 2'd3};
        return {1'b0, s};
    endfunction

    // Called with the inputs that will be sampled at rising edge n.
    // A key level is accepted once the last DEB samples all disagree with the
    // accepted level; a press then acts on the state 4 edges after its last
    // sample. A carry rise acts 3 edges after it is sampled.
    task automatic model_step(int n);
        bit all_diff;
        int e;
        logic [2:0] r;
        txn_t t;
        raw_ss[n]  = key_ss;
        raw_clr[n] = key_clr;
        raw_cy[n]  = carry_in;
        for (int k = 0; k < 2; k++) begin
            all_diff = 1'b1;
            for (int j = 0; j < DEB; j++)
                if (raw_of(k, n - j) == stb_m[k]) all_diff = 1'b0;
            if (all_diff) begin
                stb_m[k] = ~stb_m[k];
                if (stb_m[k]) begin
                    if (k == 0) ss_at[n + 4] = 1'b1;
                    else        clr_at[n + 4] = 1'b1;
                end
            end
        end
        if (raw_cy[n] && (n == 0 || !raw_cy[n - 1])) cy_at[n + 3] = 1'b1;
        e = n + 3;
        for (int i = 0; i < 2; i++) begin
            r = ref_next(m_st[i], ss_at[e], clr_at[e], cy_at[e], (i == 0));
            if (r[1:0] != m_st[i] || r[2] != m_clr[i]) begin
                t.edge_no = e;
                t.st      = r[1:0];
                t.clr     = r[2];
                if (i == 0) q0.push_back(t);
                else        q1.push_back(t);
            end
            m_st[i]  = r[1:0];
            m_clr[i] = r[2];
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    bit         sb_on = 1'b0;
    logic [1:0] last_st[2];
    logic       last_clr[2];
    txn_t       mon_t;
    bit         mon_have;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!sb_on) begin
                last_st[i]  = 2'b00;
                last_clr[i] = 1'b0;
            end else if (st[i] !== last_st[i] || clr_o[i] !== last_clr[i]) begin
                mon_have = 1'b0;
                if (i == 0 && q0.size() > 0) begin mon_t = q0.pop_front(); mon_have = 1'b1; end
                if (i == 1 && q1.size() > 0) begin mon_t = q1.pop_front(); mon_have = 1'b1; end
                if (!mon_have) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_change dut%0d: state=%0d clear=%0d at edge %0d, no change expected",
                             i, st[i], clr_o[i], cyc - 1);
                end else begin
                    chk($sformatf("edge dut%0d", i), cyc - 1, mon_t.edge_no);
                    chk($sformatf("state dut%0d e%0d", i, mon_t.edge_no), st[i], mon_t.st);
                    chk($sformatf("clear dut%0d e%0d", i, mon_t.edge_no), clr_o[i], mon_t.clr);
                    chk($sformatf("enable dut%0d e%0d", i, mon_t.edge_no), en[i], (mon_t.st == 2'd1));
                    chk($sformatf("run_led dut%0d e%0d", i, mon_t.edge_no), led[i], (mon_t.st == 2'd1));
                    $display("txn dut%0d edge %0d: state=%0d clear=%0d enable=%0d", i, cyc - 1, st[i], clr_o[i], en[i]);
                end
                last_st[i]  = st[i];
                last_clr[i] = clr_o[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int first;
        int nclr;
        int n;
        int len;
        bit v_ss, v_clr, v_cy;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_state", st[0], 0);
        chk("reset_enable", en[0], 0);
        chk("reset_clear", clr_o[0], 0);
        chk("reset_run_led", led[0], 0);

        // Clean start: key first sampled at edge 0, RUN after edge 7
        reset  = 1'b0;
        key_ss = 1'b1;
        repeat (7) @(negedge clk);
        chk("start_before_latency", st[0], 0);
        @(negedge clk);
        chk("start_state", st[0], 1);
        chk("start_enable", en[0], 1);
        chk("start_run_led", led[0], 1);
        key_ss = 1'b0;

        // Asynchronous reset between edges clears outputs immediately
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_state", st[0], 0);
        chk("async_rst_enable", en[0], 0);
        chk("async_rst_run_led", led[0], 0);
        chk("async_rst_clear", clr_o[0], 0);
        @(negedge clk);
        @(negedge clk);
        reset   = 1'b0;

        // Reset in the middle of a clr debounce
        key_clr = 1'b1;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        first = 0;
        nclr  = 0;
        for (int j = 1; j <= 14; j++) begin
            @(negedge clk);
            if (clr_o[0] === 1'b1) begin
                nclr++;
                if (first == 0) first = j;
            end
        end
        chk("rst_deb_latency", first, DEB + 4);
        chk("rst_deb_pulses", nclr, 1);
        key_clr = 1'b0;
        repeat (10) @(negedge clk);

        // Random phase against the reference model
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            stb_m[i] = 1'b0;
            m_st[i]  = 2'd0;
            m_clr[i] = 1'b0;
        end
        reset = 1'b0;
        sb_on = 1'b1;
        n = 0;
        while (n < 2600) begin
            len   = $urandom_range(1, 9);
            v_ss  = ($urandom_range(0, 99) < 45);
            v_clr = ($urandom_range(0, 99) < 8);
            v_cy  = ($urandom_range(0, 99) < 35);
            for (int l = 0; l < len; l++) begin
                key_ss   = v_ss;
                key_clr  = v_clr;
                carry_in = v_cy;
                model_step(n);
                n++;
                @(negedge clk);
            end
        end
        for (int l = 0; l < 12; l++) begin
            key_ss   = 1'b0;
            key_clr  = 1'b0;
            carry_in = 1'b0;
            model_step(n);
            n++;
            @(negedge clk);
        end
        repeat (6) @(negedge clk);
        chk("dut0_expected_left", q0.size(), 0);
        chk("dut1_expected_left", q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
